// File: rtl/bp_be_trace_replay_pkg.sv
// Shared types for the trace replay engine: opcodes, FSM states and the ROM entry layout.
// The entry macros are file-scope so any module can stamp out a width-specific struct.
`define DECLARE_BP_BE_TRACE_ENTRY_S(ch_width, payload_width) \
   typedef struct packed { \
      logic [3:0]               op; \
      logic [(ch_width)-1:0]    ch; \
      logic [(payload_width)-1:0] payload; \
   } bp_be_trace_entry_s

`define BP_BE_TRACE_ENTRY_WIDTH(ch_width, payload_width) (4 + (ch_width) + (payload_width))

package bp_be_trace_replay_pkg;

   typedef enum logic [3:0] {
      e_op_nop      = 4'd0,
      e_op_send     = 4'd1,
      e_op_recv     = 4'd2,
      e_op_recv_any = 4'd3,
      e_op_wait     = 4'd4,
      e_op_done     = 4'd5
   } bp_be_trace_op_e;

   typedef enum logic [1:0] {
      e_run  = 2'd0,
      e_wait = 2'd1,
      e_done = 2'd2
   } bp_be_trace_state_e;

   localparam int wait_width_gp = 16;

   // Channel field is never narrower than one bit, even for a single channel.
   function automatic int bp_be_ch_width_f(input int num_channels);
      return (num_channels > 2) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/bp_be_trace_replay_mc_if.sv
// Send (valid/yumi) and receive (valid/ready) channel bundle between the replay engine and the DUT.
interface bp_be_trace_replay_mc_if
 #(parameter int payload_width_p = 64
   ,parameter int num_channels_p  = 2);

   logic [num_channels_p-1:0]                 send_v;
   logic [payload_width_p-1:0]                send_data;
   logic [num_channels_p-1:0]                 send_yumi;
   logic [num_channels_p-1:0]                 recv_v;
   logic [num_channels_p*payload_width_p-1:0] recv_data;
   logic [num_channels_p-1:0]                 recv_ready;

   modport master (
      output send_v, send_data, recv_ready,
      input  send_yumi, recv_v, recv_data
   );

   modport slave (
      input  send_v, send_data, recv_ready,
      output send_yumi, recv_v, recv_data
   );

endinterface

// File: rtl/bp_be_trace_replay_timer.sv
// Wait down-counter and watchdog stall up-counter for the trace replay FSM.
// stall_expire flags that the next stall increment reaches the timeout.
module bp_be_trace_replay_timer
   import bp_be_trace_replay_pkg::*;
 #(parameter int timeout_cycles_p = 1024)
  (input  logic                     clk_i
   ,input  logic                     reset_n_i
   ,input  logic                     wait_load
   ,input  logic [wait_width_gp-1:0] wait_k
   ,input  logic                     wait_dec
   ,output logic                     wait_last
   ,input  logic                     stall_clr
   ,input  logic                     stall_inc
   ,output logic                     stall_expire
   );

   localparam int stall_width_lp = (timeout_cycles_p < 2) ? 1 : $clog2(timeout_cycles_p);
   localparam logic [stall_width_lp-1:0] stall_max_lp =
      stall_width_lp'((timeout_cycles_p == 0) ? 0 : timeout_cycles_p - 1);
   localparam logic watchdog_en_lp = (timeout_cycles_p != 0);

   logic [wait_width_gp-1:0]  wait_cnt_r;
   logic [stall_width_lp-1:0] stall_cnt_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wait_cnt_r  <= '0;
         stall_cnt_r <= '0;
      end else begin
         if (wait_load)
            wait_cnt_r <= wait_k;
         else if (wait_dec)
            wait_cnt_r <= wait_cnt_r - wait_width_gp'(1);

         if (stall_clr)
            stall_cnt_r <= '0;
         else if (stall_inc && watchdog_en_lp)
            stall_cnt_r <= stall_cnt_r + stall_width_lp'(1);
      end
   end

   assign wait_last    = (wait_cnt_r == wait_width_gp'(1));
   // Registered-only compare keeps the FSM free of a combinational loop through the timer.
   assign stall_expire = watchdog_en_lp && (stall_cnt_r == stall_max_lp);

endmodule

// File: rtl/bp_be_trace_replay_mc.sv
// Multi-channel trace replay: walks a combinational ROM, drives valid/yumi sends and checks
// valid/ready receives on one of several channel pairs, with waits, watchdog and error count.
module bp_be_trace_replay_mc
   import bp_be_trace_replay_pkg::*;
 #(parameter int payload_width_p  = 64
   ,parameter int rom_addr_width_p = 8
   ,parameter int num_channels_p   = 2
   ,parameter int timeout_cycles_p = 1024
   ,parameter int err_cnt_width_p  = 8
   ,localparam int ch_width_lp  = bp_be_ch_width_f(num_channels_p)
   ,localparam int rom_width_lp = `BP_BE_TRACE_ENTRY_WIDTH(ch_width_lp, payload_width_p))
  (input  logic                        clk_i
   ,input  logic                        reset_n_i
   ,input  logic                        en_i
   ,output logic [rom_addr_width_p-1:0] rom_addr_o
   ,input  logic [rom_width_lp-1:0]     rom_data_i
   ,bp_be_trace_replay_mc_if.master     bus
   ,output logic                        done_o
   ,output logic                        error_o
   ,output logic                        timeout_o
   ,output logic [err_cnt_width_p-1:0]  err_cnt_o
   );

   `DECLARE_BP_BE_TRACE_ENTRY_S(ch_width_lp, payload_width_p);

   localparam logic [ch_width_lp:0] num_ch_lp = (ch_width_lp+1)'(num_channels_p);

   bp_be_trace_entry_s entry;
   assign entry = rom_data_i;

   bp_be_trace_state_e            state_r, state_n;
   logic [rom_addr_width_p-1:0]   addr_r, addr_n;

   logic                          ch_ok;
   logic [num_channels_p-1:0]     ch_onehot;
   logic [payload_width_p-1:0]    sel_data;
   logic                          sel_yumi, sel_v;
   logic                          send_act, recv_act, hs;
   logic                          advance, mismatch, term, to_set;
   logic                          wait_load, wait_dec, wait_last;
   logic                          stall_clr, stall_inc, stall_expire;
   logic [num_channels_p-1:0]     send_v, recv_ready;

   // Channel decode: one-hot select plus the matching receive lane.
   always_comb begin
      ch_onehot = '0;
      sel_data  = '0;
      for (int k = 0; k < num_channels_p; k++) begin
         if (entry.ch == ch_width_lp'(k)) begin
            ch_onehot[k] = 1'b1;
            sel_data     = bus.recv_data[k*payload_width_p +: payload_width_p];
         end
      end
   end

   assign ch_ok    = ({1'b0, entry.ch} < num_ch_lp);
   assign sel_yumi = |(ch_onehot & bus.send_yumi);
   assign sel_v    = |(ch_onehot & bus.recv_v);

   always_comb begin
      state_n   = state_r;
      addr_n    = addr_r;
      send_act  = 1'b0;
      recv_act  = 1'b0;
      advance   = 1'b0;
      mismatch  = 1'b0;
      term      = 1'b0;
      to_set    = 1'b0;
      wait_load = 1'b0;
      wait_dec  = 1'b0;
      stall_inc = 1'b0;

      // Handshake offers depend only on state and the ROM entry.
      if (state_r == e_run && ch_ok) begin
         send_act = (entry.op == e_op_send);
         recv_act = (entry.op == e_op_recv) || (entry.op == e_op_recv_any);
      end
      hs = en_i && ((send_act && sel_yumi) || (recv_act && sel_v));

      if (en_i) begin
         case (state_r)
            e_run: begin
               case (entry.op)
                  e_op_nop: advance = 1'b1;
                  e_op_send, e_op_recv, e_op_recv_any: begin
                     if (!ch_ok)
                        term = 1'b1;
                     else if (hs) begin
                        advance  = 1'b1;
                        mismatch = (entry.op == e_op_recv) && (sel_data != entry.payload);
                     end else
                        stall_inc = 1'b1;
                  end
                  e_op_wait: begin
                     if (entry.payload[wait_width_gp-1:0] == '0)
                        advance = 1'b1;
                     else begin
                        wait_load = 1'b1;
                        state_n   = e_wait;
                     end
                  end
                  e_op_done: state_n = e_done;
                  default:   term    = 1'b1;
               endcase
            end
            e_wait: begin
               if (wait_last) begin
                  advance = 1'b1;
                  state_n = e_run;
               end else
                  wait_dec = 1'b1;
            end
            default: ;
         endcase
      end

      if (advance) begin
         if (&addr_r)
            term = 1'b1;
         else
            addr_n = addr_r + rom_addr_width_p'(1);
      end

      // A handshake never raises stall_inc, so it always beats the watchdog.
      if (stall_inc && stall_expire) begin
         term   = 1'b1;
         to_set = 1'b1;
      end

      if (term)
         state_n = e_done;
   end

   assign stall_clr = hs | advance;

   bp_be_trace_replay_timer #(.timeout_cycles_p(timeout_cycles_p)) timer (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .wait_load    (wait_load),
      .wait_k       (entry.payload[wait_width_gp-1:0]),
      .wait_dec     (wait_dec),
      .wait_last    (wait_last),
      .stall_clr    (stall_clr),
      .stall_inc    (stall_inc),
      .stall_expire (stall_expire)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= e_run;
         addr_r    <= '0;
         done_o    <= 1'b0;
         error_o   <= 1'b0;
         timeout_o <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         state_r   <= state_n;
         addr_r    <= addr_n;
         done_o    <= done_o | (state_n == e_done);
         error_o   <= error_o | term | mismatch;
         timeout_o <= timeout_o | to_set;
         if (mismatch && !(&err_cnt_o))
            err_cnt_o <= err_cnt_o + err_cnt_width_p'(1);
      end
   end

   // Reset gating makes the offers drop the instant reset asserts.
   assign send_v     = (reset_n_i && en_i && send_act) ? ch_onehot : '0;
   assign recv_ready = (reset_n_i && en_i && recv_act) ? ch_onehot : '0;

   assign bus.send_v     = send_v;
   assign bus.recv_ready = recv_ready;
   assign bus.send_data  = (|send_v) ? entry.payload : '0;
   assign rom_addr_o     = addr_r;

endmodule

// File: tb/tb_bp_be_trace_replay_mc.sv
// Directed bench for bp_be_trace_replay_mc: ROM programs per scenario, send scoreboard,
// immediate-assertion checks sampled 3 time units after each rising edge.
module tb_bp_be_trace_replay_mc;
   import bp_be_trace_replay_pkg::*;

   // Three channels so that ch=3 is representable and out of range.
   localparam int pw = 64, aw = 8, nc = 3, to = 16, ew = 2, cw = 2;
   localparam int rw = 4 + cw + pw;

   typedef struct packed {
      logic [cw-1:0] ch;
      logic [pw-1:0] payload;
   } exp_send_t;

   logic          clk = 1'b0, reset_n = 1'b0, en = 1'b0;
   logic [aw-1:0] rom_addr;
   logic [rw-1:0] rom_data;
   logic          done, error, timeout;
   logic [ew-1:0] err_cnt;
   logic [rw-1:0] rom [256];
   exp_send_t     sb [$];
   int            checks = 0, errors = 0;

   bp_be_trace_replay_mc_if #(.payload_width_p(pw), .num_channels_p(nc)) bus ();

   assign rom_data = rom[rom_addr];
   always #5 clk = ~clk;

   bp_be_trace_replay_mc #(
      .payload_width_p(pw), .rom_addr_width_p(aw), .num_channels_p(nc),
      .timeout_cycles_p(to), .err_cnt_width_p(ew)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .bus(bus),
      .done_o(done), .error_o(error), .timeout_o(timeout), .err_cnt_o(err_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [rw-1:0] mk(input int op, input int ch, input logic [pw-1:0] pl);
      return {4'(op), cw'(ch), pl};
   endfunction

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   // Scoreboard pop at a send handshake.
   task automatic expect_send(input string tag);
      exp_send_t e;
      check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_v"}, 64'(bus.send_v), 64'(3'b001 << e.ch));
         check({tag, "_data"}, bus.send_data, e.payload);
      end
   endtask

   task automatic do_reset();
      en = 1'b0;
      bus.send_yumi = '0;
      bus.recv_v    = '0;
      bus.recv_data = '0;
      reset_n = 1'b0;
      #7;
      check("rst_send_v", 64'(bus.send_v), 64'd0);
      check("rst_ready", 64'(bus.recv_ready), 64'd0);
      check("rst_data", bus.send_data, 64'd0);
      check("rst_addr", 64'(rom_addr), 64'd0);
      check("rst_flags", 64'({done, error, timeout}), 64'd0);
      check("rst_errcnt", 64'(err_cnt), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int idle, rdy_cnt;

      // Three back-to-back sends with yumi tied high, then done.
      rom_clear();
      rom[0] = mk(e_op_send, 0, 64'h11); sb.push_back('{ch: 2'd0, payload: 64'h11});
      rom[1] = mk(e_op_send, 1, 64'h22); sb.push_back('{ch: 2'd1, payload: 64'h22});
      rom[2] = mk(e_op_send, 0, 64'h33); sb.push_back('{ch: 2'd0, payload: 64'h33});
      rom[3] = mk(e_op_done, 0, 64'h0);
      do_reset();
      en = 1'b1; bus.send_yumi = '1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (c < 3) begin
            check("t1_onehot", 64'($onehot(bus.send_v)), 64'd1);
            expect_send("t1");
         end else
            check("t1_idle_at_done", 64'(bus.send_v), 64'd0);
         check("t1_done_early", 64'(done), 64'd0);
         tick();
      end
      #1;
      check("t1_done_cycle4", 64'(done), 64'd1);
      check("t1_no_error", 64'(error), 64'd0);
      check("t1_addr_hold", 64'(rom_addr), 64'd3);

      // recv ch1 expecting 0xAB; bench answers 0xAC after 5 stall cycles.
      rom_clear();
      rom[0] = mk(e_op_recv, 1, 64'hAB);
      rom[1] = mk(e_op_done, 0, 64'h0);
      do_reset();
      en = 1'b1;
      bus.recv_data[pw +: pw] = 64'hAC;
      rdy_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         bus.recv_v = (c == 5) ? 3'b010 : 3'b000;
         #1;
         if (bus.recv_ready[1]) rdy_cnt++;
         check("t2_ready_val", 64'(bus.recv_ready), 64'b010);
         check("t2_errcnt_pre", 64'(err_cnt), 64'd0);
         tick();
      end
      bus.recv_v = '0;
      #1;
      check("t2_ready_cycles", 64'(rdy_cnt), 64'd6);
      check("t2_errcnt", 64'(err_cnt), 64'd1);
      check("t2_error", 64'(error), 64'd1);
      check("t2_addr", 64'(rom_addr), 64'd1);
      tick(); #1;
      check("t2_done", 64'(done), 64'd1);

      // Matching recv and recv_any leave no error; then four mismatches saturate a 2-bit count.
      rom_clear();
      rom[0] = mk(e_op_recv, 2, 64'h55);
      rom[1] = mk(e_op_recv_any, 0, 64'h0);
      for (int i = 2; i < 6; i++) rom[i] = mk(e_op_recv, 0, 64'h0);
      rom[6] = mk(e_op_done, 0, 64'h0);
      do_reset();
      en = 1'b1; bus.recv_v = '1;
      bus.recv_data[0 +: pw]    = 64'h5;
      bus.recv_data[2*pw +: pw] = 64'h55;
      tick(); tick(); #1;
      check("t3_match_errcnt", 64'(err_cnt), 64'd0);
      check("t3_match_error", 64'(error), 64'd0);
      tick(); tick(); tick(); #1;
      check("t3_errcnt_3", 64'(err_cnt), 64'd3);
      tick(); #1;
      check("t3_errcnt_sat", 64'(err_cnt), 64'd3);
      check("t3_error_sat", 64'(error), 64'd1);
      check("t3_addr", 64'(rom_addr), 64'd6);
      bus.recv_v = '0;

      // wait K=10 between two sends: 11 empty cycles between them.
      rom_clear();
      rom[0] = mk(e_op_send, 0, 64'h1);
      rom[1] = mk(e_op_wait, 0, 64'd10);
      rom[2] = mk(e_op_send, 1, 64'h2);
      rom[3] = mk(e_op_done, 0, 64'h0);
      sb.push_back('{ch: 2'd0, payload: 64'h1});
      sb.push_back('{ch: 2'd1, payload: 64'h2});
      do_reset();
      en = 1'b1; bus.send_yumi = '1;
      #1; expect_send("t4_first"); tick();
      idle = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.send_v != '0) break;
         idle++;
         tick();
      end
      check("t4_wait_gap", 64'(idle), 64'd11);
      expect_send("t4_second");

      // Same program with en low for 5 cycles mid-wait: timer pauses.
      sb.push_back('{ch: 2'd0, payload: 64'h1});
      sb.push_back('{ch: 2'd1, payload: 64'h2});
      do_reset();
      en = 1'b1; bus.send_yumi = '1;
      #1; expect_send("t5_first"); tick();
      idle = 0;
      for (int c = 0; c < 60; c++) begin
         en = !(c >= 4 && c < 9);
         #1;
         if (!en) check("t5_v_gated", 64'(bus.send_v), 64'd0);
         if (bus.send_v != '0) break;
         if (en) idle++;
         tick();
      end
      check("t5_wait_gap_en", 64'(idle), 64'd11);
      expect_send("t5_second");

      // Watchdog: send with yumi low times out after 16 cycles.
      rom_clear();
      rom[0] = mk(e_op_send, 0, 64'h77);
      do_reset();
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         if (c == 15) begin
            check("t6_v_before", 64'(bus.send_v), 64'b001);
            check("t6_timeout_before", 64'(timeout), 64'd0);
         end
         tick();
      end
      #1;
      check("t6_timeout", 64'(timeout), 64'd1);
      check("t6_error", 64'(error), 64'd1);
      check("t6_done", 64'(done), 64'd1);
      check("t6_v_drop", 64'(bus.send_v), 64'd0);

      // Handshake on the would-be timeout cycle wins.
      rom[1] = mk(e_op_done, 0, 64'h0);
      do_reset();
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         bus.send_yumi = (c == 15) ? 3'b111 : 3'b000;
         tick();
      end
      #1;
      check("t7_no_timeout", 64'(timeout), 64'd0);
      check("t7_addr", 64'(rom_addr), 64'd1);
      tick(); #1;
      check("t7_done", 64'(done), 64'd1);
      check("t7_no_error", 64'(error), 64'd0);

      // en low mid-send: the stall count holds across 20 disabled cycles.
      rom_clear();
      rom[0] = mk(e_op_send, 1, 64'h9);
      do_reset();
      en = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      en = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      check("t8_timeout_paused", 64'(timeout), 64'd0);
      en = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      #1;
      check("t8_timeout_pre", 64'(timeout), 64'd0);
      check("t8_v_resumed", 64'(bus.send_v), 64'b010);
      tick(); #1;
      check("t8_timeout", 64'(timeout), 64'd1);

      // Reset pulsed mid-send drops v_o and the address immediately.
      rom_clear();
      rom[1] = mk(e_op_send, 2, 64'h5);
      do_reset();
      en = 1'b1;
      tick(); #1;
      check("t9_addr_pre", 64'(rom_addr), 64'd1);
      check("t9_v_pre", 64'(bus.send_v), 64'b100);
      #1; reset_n = 1'b0; #1;
      check("t9_v_async", 64'(bus.send_v), 64'd0);
      check("t9_addr_async", 64'(rom_addr), 64'd0);

      // Illegal opcode 9, then send to channel 3 of 3.
      rom_clear();
      rom[0] = mk(9, 0, 64'h0);
      do_reset();
      en = 1'b1; bus.send_yumi = '1; bus.recv_v = '1;
      #1;
      check("t10_no_hs", 64'({bus.send_v, bus.recv_ready}), 64'd0);
      tick(); #1;
      check("t10_flags", 64'({done, error, timeout}), 64'b110);
      rom[0] = mk(e_op_send, 3, 64'h3);
      do_reset();
      en = 1'b1; bus.send_yumi = '1; bus.recv_v = '1;
      #1;
      check("t11_no_hs", 64'({bus.send_v, bus.recv_ready}), 64'd0);
      tick(); #1;
      check("t11_flags", 64'({done, error, timeout}), 64'b110);

      // 256 nops: stepping past address 0xFF is an error, address holds.
      rom_clear();
      do_reset();
      en = 1'b1;
      for (int c = 0; c < 256; c++) begin
         if (c == 255) begin
            #1;
            check("t12_addr_last", 64'(rom_addr), 64'd255);
            check("t12_done_pre", 64'(done), 64'd0);
         end
         tick();
      end
      #1;
      check("t12_flags", 64'({done, error}), 64'b11);
      check("t12_addr_hold", 64'(rom_addr), 64'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
